// File: rtl/l2_port_arbiter.sv
// Two-requester round-robin arbiter in front of one L2 memory port. In-order responses are
// routed back via an ID FIFO; out-of-range requests get a registered error response.
module l2_port_arbiter #(
  parameter int unsigned          AddrWidth      = 48,
  parameter int unsigned          DataWidth      = 64,
  parameter logic [AddrWidth-1:0] PortBase       = 'h78000000,
  parameter logic [AddrWidth-1:0] PortSize       = 'h00200000,
  parameter int unsigned          MaxOutstanding = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [1:0]               req_i,
  output logic [1:0]               gnt_o,
  input  logic [2*AddrWidth-1:0]   addr_i,
  input  logic [1:0]               we_i,
  input  logic [2*DataWidth/8-1:0] be_i,
  input  logic [2*DataWidth-1:0]   wdata_i,
  output logic [1:0]               rvalid_o,
  output logic [2*DataWidth-1:0]   rdata_o,
  output logic [1:0]               err_o,
  output logic                     mem_req_o,
  input  logic                     mem_gnt_i,
  output logic [AddrWidth-1:0]     mem_addr_o,
  output logic                     mem_we_o,
  output logic [DataWidth/8-1:0]   mem_be_o,
  output logic [DataWidth-1:0]     mem_wdata_o,
  input  logic                     mem_rvalid_i,
  input  logic [DataWidth-1:0]     mem_rdata_i,
  input  logic                     mem_err_i
);

  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [AddrWidth:0]  PortLo  = {1'b0, PortBase};
  localparam logic [AddrWidth:0]  PortHi  = {1'b0, PortBase} + {1'b0, PortSize};
  localparam logic [CntWidth-1:0] CntMax  = CntWidth'(MaxOutstanding);
  localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(MaxOutstanding - 1);

  logic                      prio_q;
  logic [MaxOutstanding-1:0] id_q;
  logic [PtrWidth-1:0]       rd_ptr_q, wr_ptr_q;
  logic [CntWidth-1:0]       cnt_q;
  logic                      err_pend_q, err_id_q;
  logic                      spurious_q;

  logic                 win, any_req, in_range, empty, pop, push, can_fwd, err_gnt, grant, head;
  logic [AddrWidth-1:0] win_addr;

  // Both requesting: prio decides; otherwise whoever requests.
  assign win      = req_i[1] & (~req_i[0] | prio_q);
  assign any_req  = |req_i;
  assign win_addr = win ? addr_i[2*AddrWidth-1:AddrWidth] : addr_i[AddrWidth-1:0];
  assign in_range = ({1'b0, win_addr} >= PortLo) && ({1'b0, win_addr} < PortHi);
  assign empty    = (cnt_q == '0);
  assign pop      = mem_rvalid_i & ~empty;
  assign head     = id_q[rd_ptr_q];

  // A full FIFO still accepts a push when the same cycle pops the head.
  assign can_fwd = ~rst_i & any_req & in_range & ~err_pend_q & ((cnt_q != CntMax) | pop);
  assign err_gnt = ~rst_i & any_req & ~in_range & ~err_pend_q & empty & ~mem_rvalid_i;
  assign push    = can_fwd & mem_gnt_i;
  assign grant   = push | err_gnt;

  assign gnt_o       = grant ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign mem_req_o   = can_fwd;
  assign mem_addr_o  = can_fwd ? (win_addr - PortBase) : '0;
  assign mem_we_o    = can_fwd & we_i[win];
  assign mem_be_o    = !can_fwd ? '0 : (win ? be_i[2*BeWidth-1:BeWidth] : be_i[BeWidth-1:0]);
  assign mem_wdata_o = !can_fwd ? '0 :
                       (win ? wdata_i[2*DataWidth-1:DataWidth] : wdata_i[DataWidth-1:0]);

  always_comb begin
    rvalid_o = 2'b00;
    err_o    = 2'b00;
    rdata_o  = '0;
    if (pop) begin
      rvalid_o[head] = 1'b1;
      err_o[head]    = mem_err_i;
      if (head) rdata_o[2*DataWidth-1:DataWidth] = mem_rdata_i;
      else      rdata_o[DataWidth-1:0]           = mem_rdata_i;
    end
    if (err_pend_q) begin
      rvalid_o[err_id_q] = 1'b1;
      err_o[err_id_q]    = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q     <= 1'b0;
      id_q       <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      err_pend_q <= 1'b0;
      err_id_q   <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      if (pop) rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
      if (push) begin
        id_q[wr_ptr_q] <= win;
        wr_ptr_q       <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (mem_rvalid_i && empty) spurious_q <= 1'b1;
      err_pend_q <= err_gnt;
      if (err_gnt) err_id_q <= win;
      if (grant) prio_q <= ~win;
    end
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Self-checking bench for l2_port_arbiter: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_l2_port_arbiter;

  localparam int unsigned AW   = 48;
  localparam int unsigned DW   = 64;
  localparam int unsigned MAXO = 4;
  localparam longint unsigned BASE = 64'h78000000;
  localparam longint unsigned SIZE = 64'h00200000;

  logic            clk = 1'b0, rst = 1'b0;
  logic [1:0]      req_i, gnt_o, we_i, rvalid_o, err_o;
  logic [2*AW-1:0] addr_i;
  logic [15:0]     be_i;
  logic [127:0]    wdata_i, rdata_o;
  logic            mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, mem_err_i;
  logic [AW-1:0]   mem_addr_o;
  logic [7:0]      mem_be_o;
  logic [DW-1:0]   mem_wdata_o, mem_rdata_i;

  int checks = 0;
  int failures = 0;

  l2_port_arbiter dut (
    .clk_i(clk), .rst_i(rst), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i),
    .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;  logic [47:0] a0;   logic [47:0] a1;
    logic        mg;   logic        mrv;  logic [63:0] mrd;  logic me;
    logic [1:0]  gnt;  logic        mreq; logic [47:0] maddr;
    logic [1:0]  rv;   logic [1:0]  err;  logic [63:0] rd0;  logic [63:0] rd1;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [1:0] rq, input logic [47:0] a0, input logic [47:0] a1,
                        input logic mg, input logic mrv, input logic [63:0] rd, input logic me);
    req_i = rq; addr_i = {a1, a0}; mem_gnt_i = mg; mem_rvalid_i = mrv;
    mem_rdata_i = rd; mem_err_i = me; we_i = 2'b00; be_i = '0; wdata_i = '0;
  endtask

  task automatic exp_out(input string tag, input logic [1:0] g, input logic mr,
                         input logic [1:0] rv, input logic [1:0] er);
    chk({tag, "_gnt"}, gnt_o, g);
    chk({tag, "_mem_req"}, mem_req_o, mr);
    chk({tag, "_rvalid"}, rvalid_o, rv);
    chk({tag, "_err"}, err_o, er);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_in(2'b00, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model state: round-robin pointer, in-order ID queue, pending error response.
  int m_prio;
  int m_q[$];
  bit m_ep;
  int m_eid;

  function automatic bit in_rng(input logic [47:0] a);
    longint unsigned x = 64'(a);
    return (x >= BASE) && (x < BASE + SIZE);
  endfunction

  function automatic logic [47:0] pick_addr();
    int sel = int'($urandom_range(0, 9));
    case (sel)
      0:       return 48'(BASE - 1);
      1:       return 48'(BASE + SIZE);
      2:       return 48'(BASE + SIZE - 1);
      3:       return {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
      default: return 48'(BASE + 64'($urandom_range(0, 32'h1FFFFF)));
    endcase
  endfunction

  task automatic model_cycle(input int cyc);
    bit any, inr, pop, fwd, eg;
    int win, h;
    logic [47:0] wa;
    logic [1:0] egnt, erv, eerr;
    logic [127:0] erd;
    any  = (req_i != 2'b00);
    win  = (req_i == 2'b11) ? m_prio : (req_i[1] ? 1 : 0);
    wa   = (win == 1) ? addr_i[95:48] : addr_i[47:0];
    inr  = in_rng(wa);
    pop  = mem_rvalid_i && (m_q.size() > 0);
    fwd  = any && inr && !m_ep && ((m_q.size() < MAXO) || pop);
    eg   = any && !inr && !m_ep && (m_q.size() == 0) && !mem_rvalid_i;
    egnt = ((fwd && mem_gnt_i) || eg) ? 2'(1 << win) : 2'b00;
    erv = 2'b00; eerr = 2'b00; erd = '0;
    if (pop) begin
      h = m_q[0];
      erv[h] = 1'b1;
      eerr[h] = mem_err_i;
      erd = 128'(mem_rdata_i) << (64 * h);
    end
    if (m_ep) begin
      erv[m_eid] = 1'b1;
      eerr[m_eid] = 1'b1;
    end
    chk($sformatf("rnd%0d_gnt", cyc), gnt_o, egnt);
    chk($sformatf("rnd%0d_mem_req", cyc), mem_req_o, fwd);
    chk($sformatf("rnd%0d_rvalid", cyc), rvalid_o, erv);
    chk($sformatf("rnd%0d_err", cyc), err_o, eerr);
    chk($sformatf("rnd%0d_rdata", cyc), rdata_o, erd);
    if (fwd) begin
      chk($sformatf("rnd%0d_cmd", cyc), {mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o},
          {48'(64'(wa) - BASE), we_i[win], be_i[8*win +: 8], wdata_i[64*win +: 64]});
    end
    if (pop) void'(m_q.pop_front());
    if (fwd && mem_gnt_i) m_q.push_back(win);
    m_ep = eg;
    if (eg) m_eid = win;
    if (egnt != 2'b00) m_prio = 1 - win;
  endtask

  vec_t tbl[13];

  initial begin
    set_in(2'b11, 48'h78000000, 48'h78000040, 1'b1, 1'b1, 64'h55, 1'b0);
    #1 rst = 1'b1;
    #1;
    exp_out("reset", 2'b00, 1'b0, 2'b00, 2'b00);
    chk("reset_rdata", rdata_o, '0);
    chk("reset_spurious", dut.spurious_q, 1'b0);
    do_reset();

    // Round-robin, interleaved responses and address boundaries, from reset.
    tbl[0]  = '{2'b11, 48'h78000000, 48'h78000040, 1, 0, 0, 0, 2'b01, 1, 48'h0, 0, 0, 0, 0};
    tbl[1]  = '{2'b11, 48'h78000000, 48'h78000040, 1, 0, 0, 0, 2'b10, 1, 48'h40, 0, 0, 0, 0};
    tbl[2]  = '{2'b01, 48'h78000080, 48'h0, 1, 0, 0, 0, 2'b01, 1, 48'h80, 0, 0, 0, 0};
    tbl[3]  = '{2'b00, 48'h0, 48'h0, 1, 1, 64'hD0, 0, 2'b00, 0, 0, 2'b01, 0, 64'hD0, 0};
    tbl[4]  = '{2'b00, 48'h0, 48'h0, 1, 1, 64'hD1, 1, 2'b00, 0, 0, 2'b10, 2'b10, 0, 64'hD1};
    tbl[5]  = '{2'b00, 48'h0, 48'h0, 1, 1, 64'hD2, 0, 2'b00, 0, 0, 2'b01, 0, 64'hD2, 0};
    tbl[6]  = '{2'b10, 48'h0, 48'h78200000, 1, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{2'b10, 48'h0, 48'h78200000, 1, 0, 0, 0, 2'b00, 0, 0, 2'b10, 2'b10, 0, 0};
    tbl[8]  = '{2'b01, 48'h77FFFFFF, 48'h0, 1, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{2'b00, 48'h0, 48'h0, 1, 0, 0, 0, 2'b00, 0, 0, 2'b01, 2'b01, 0, 0};
    tbl[10] = '{2'b01, 48'h781FFFFF, 48'h0, 0, 0, 0, 0, 2'b00, 1, 48'h1FFFFF, 0, 0, 0, 0};
    tbl[11] = '{2'b01, 48'h781FFFFF, 48'h0, 1, 0, 0, 0, 2'b01, 1, 48'h1FFFFF, 0, 0, 0, 0};
    tbl[12] = '{2'b00, 48'h0, 48'h0, 1, 1, 64'hD3, 0, 2'b00, 0, 0, 2'b01, 0, 64'hD3, 0};
    for (int i = 0; i < 13; i++) begin
      set_in(tbl[i].req, tbl[i].a0, tbl[i].a1, tbl[i].mg, tbl[i].mrv, tbl[i].mrd, tbl[i].me);
      #2;
      exp_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].mreq, tbl[i].rv, tbl[i].err);
      if (tbl[i].mreq) chk($sformatf("vec%0d_mem_addr", i), mem_addr_o, tbl[i].maddr);
      chk($sformatf("vec%0d_rdata", i), rdata_o, {tbl[i].rd1, tbl[i].rd0});
      @(negedge clk);
    end

    // Outstanding limit: fifth request waits until a response frees a slot in the same cycle.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(2'b01, 48'(BASE + 8 * i), '0, 1'b1, 1'b0, '0, 1'b0);
      #2 exp_out("fill", 2'b01, 1'b1, 2'b00, 2'b00);
      @(negedge clk);
    end
    set_in(2'b01, 48'h78000020, '0, 1'b1, 1'b0, '0, 1'b0);
    #2 exp_out("full_blocked", 2'b00, 1'b0, 2'b00, 2'b00);
    @(negedge clk);
    set_in(2'b01, 48'h78000020, '0, 1'b1, 1'b1, 64'hAA, 1'b0);
    #2 exp_out("full_pop_push", 2'b01, 1'b1, 2'b01, 2'b00);
    chk("full_pop_push_rdata", rdata_o, 128'hAA);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      set_in(2'b00, '0, '0, 1'b0, 1'b1, 64'(i + 1), 1'b0);
      #2 exp_out("drain", 2'b00, 1'b0, 2'b01, 2'b00);
      @(negedge clk);
    end

    // Out-of-range request waits for both outstanding responses before its error response.
    for (int i = 0; i < 2; i++) begin
      set_in(2'b01, 48'h78000100, '0, 1'b1, 1'b0, '0, 1'b0);
      #2 exp_out("oor_setup", 2'b01, 1'b1, 2'b00, 2'b00);
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      set_in(2'b10, '0, 48'h78200100, 1'b1, 1'b0, '0, 1'b0);
      #2 exp_out("oor_wait", 2'b00, 1'b0, 2'b00, 2'b00);
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      set_in(2'b10, '0, 48'h78200100, 1'b1, 1'b1, 64'hB0 + 64'(i), 1'b0);
      #2 exp_out("oor_resp", 2'b00, 1'b0, 2'b01, 2'b00);
      @(negedge clk);
    end
    set_in(2'b10, '0, 48'h78200100, 1'b1, 1'b0, '0, 1'b0);
    #2 exp_out("oor_grant", 2'b10, 1'b0, 2'b00, 2'b00);
    @(negedge clk);
    set_in(2'b00, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    #2 exp_out("oor_err", 2'b00, 1'b0, 2'b10, 2'b10);
    chk("oor_err_rdata", rdata_o, '0);
    @(negedge clk);

    // Asynchronous reset with three outstanding; later responses are spurious.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(2'b01, 48'h78000000, '0, 1'b1, 1'b0, '0, 1'b0);
      #2 exp_out("rst_fill", 2'b01, 1'b1, 2'b00, 2'b00);
      @(negedge clk);
    end
    set_in(2'b01, 48'h78000000, '0, 1'b1, 1'b1, 64'hCC, 1'b0);
    #2 exp_out("rst_pre", 2'b01, 1'b1, 2'b01, 2'b00);
    #1 rst = 1'b1;
    #1 exp_out("rst_async", 2'b00, 1'b0, 2'b00, 2'b00);
    chk("rst_async_rdata", rdata_o, '0);
    @(negedge clk);
    rst = 1'b0;
    set_in(2'b00, '0, '0, 1'b0, 1'b1, 64'hDD, 1'b0);
    #2 exp_out("rst_after", 2'b00, 1'b0, 2'b00, 2'b00);
    chk("rst_spurious_clear", dut.spurious_q, 1'b0);
    @(negedge clk);
    chk("rst_spurious_set", dut.spurious_q, 1'b1);
    set_in(2'b00, '0, '0, 1'b0, 1'b0, '0, 1'b0);

    // Randomized run against the reference model.
    do_reset();
    m_prio = 0; m_q.delete(); m_ep = 0; m_eid = 0;
    for (int c = 0; c < 3000; c++) begin
      req_i        = 2'($urandom_range(0, 3));
      addr_i       = {pick_addr(), pick_addr()};
      we_i         = 2'($urandom);
      be_i         = 16'($urandom);
      wdata_i      = {$urandom(), $urandom(), $urandom(), $urandom()};
      mem_gnt_i    = ($urandom_range(0, 3) != 0);
      mem_rvalid_i = ($urandom_range(0, 2) == 0);
      mem_rdata_i  = {$urandom(), $urandom()};
      mem_err_i    = 1'($urandom);
      #2 model_cycle(c);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l2_port_arbiter.md
L2_PORT_ARBITER -- requirements
Module: l2_port_arbiter

Interface
REQ-001 SHALL have parameter AddrWidth, default 48, requester/memory address width.
REQ-002 SHALL have parameter DataWidth, default 64, data width; byte-enable width = DataWidth/8.
REQ-003 SHALL have parameter PortBase, default 'h78000000, first byte address of the served L2 port.
REQ-004 SHALL have parameter PortSize, default 'h00200000, byte size of the served L2 port.
REQ-005 SHALL have parameter MaxOutstanding, default 4, ≥1, maximum forwarded requests awaiting response.
REQ-006 clk_i  in  1  sole clock; all state on rising edge.
REQ-007 rst_i  in  1  reset, asynchronous, active-high.
REQ-008 req_i / gnt_o  in/out  2  per-requester request / grant (index 0 = host, 1 = safety island).
REQ-009 addr_i  in  2×AddrWidth; we_i  in  2; be_i  in  2×DataWidth/8; wdata_i  in  2×DataWidth — per-requester command.
REQ-010 rvalid_o  out  2; rdata_o  out  2×DataWidth; err_o  out  2 — per-requester response.
REQ-011 mem_req_o  out  1; mem_gnt_i  in  1; mem_addr_o  out  AddrWidth (byte offset from PortBase); mem_we_o  out  1; mem_be_o  out  DataWidth/8; mem_wdata_o  out  DataWidth.
REQ-012 mem_rvalid_i  in  1; mem_rdata_i  in  DataWidth; mem_err_i  in  1 — in-order memory response.

Function
REQ-013 Request in range iff PortBase ≤ addr < PortBase+PortSize, compared at AddrWidth+1 bits (no wrap).
REQ-014 Arbitration round-robin: pointer prio (reset 0) gives priority to requester prio when both request; a granted transfer sets prio to the other index.
REQ-015 In-range winner: mem_req_o=1 and command forwarded combinationally; gnt_o[winner]=mem_gnt_i; loser gnt_o=0.
REQ-016 Forwarding blocked (mem_req_o=0, gnt_o=0) while outstanding count = MaxOutstanding, unless mem_rvalid_i pops an entry that cycle.
REQ-017 Each forwarded handshake (mem_req_o & mem_gnt_i) pushes winner ID into an in-order ID FIFO of depth MaxOutstanding.
REQ-018 mem_rvalid_i pops FIFO head; asserts rvalid_o[head] with rdata_o=mem_rdata_i, err_o=mem_err_i, same cycle (zero added latency).
REQ-019 Simultaneous push and pop: count unchanged; pop-then-push ordering, no loss even when full.
REQ-020 mem_rvalid_i with empty FIFO: ignored, no rvalid_o; sticky internal flag spurious_q set (visible for assertions).
REQ-021 Out-of-range winner: not forwarded; granted only when FIFO empty and no mem_rvalid_i in that cycle; rvalid_o[winner]=1, err_o=1, rdata_o=0 exactly one cycle after grant (registered).
REQ-022 While an error response is pending (the cycle after an out-of-range grant) no new grant issues.
REQ-023 Requesters hold req/command until gnt; arbiter never de-grants mid-cycle; a requester dropping req before gnt is legal, arbitration re-evaluates next cycle.
REQ-024 Outputs rvalid_o, err_o, rdata_o for non-selected requesters are 0.

Reset
REQ-025 rst_i asserted: gnt_o=0, mem_req_o=0, rvalid_o=0, err_o=0, rdata_o=0, prio=0, FIFO empty, count=0, error-pending=0, spurious_q=0, immediately (asynchronous).
REQ-026 Reset mid-transaction discards outstanding IDs; memory responses arriving after reset release are treated as spurious per REQ-020.
REQ-027 First grant possible in the first rising edge after rst_i deassertion.

Verification
REQ-028 Both req, addr 'h78000000/'h78000040, mem_gnt_i=1 -> gnt to 0 then 1 on consecutive cycles, prio toggles, mem_addr_o 'h0 then 'h40.
REQ-029 Requester 0 issues 4 reads (MaxOutstanding=4), mem_rvalid_i held 0 -> 5th request not granted; one mem_rvalid_i -> 5th granted same cycle, rvalid_o[0]=1.
REQ-030 Interleaved grants 0,1,0 with responses D0,D1,D2 -> rvalid_o[0]/rdata D0, rvalid_o[1]/D1, rvalid_o[0]/D2 in order.
REQ-031 Requester 1 addr 'h78200000 (=Base+Size) with FIFO empty -> gnt_o[1]=1, mem_req_o=0, next cycle rvalid_o[1]=1, err_o[1]=1, rdata 0.
REQ-032 Out-of-range request while 2 outstanding -> held ungranted until both responses returned, then error response.
REQ-033 rst_i pulsed with 3 outstanding -> all outputs 0 asynchronously; later mem_rvalid_i produces no rvalid_o, spurious_q=1.
